dla_act_packer: RTL and testbench
=================================

// Module: dla_act_packer
// PURPOSE
//  Consumes the 16-bit activation stream leaving the LeakyReLU stage and packs two
//  halfwords into each 32-bit word for the DLA output buffer.
//  Generates an incrementing byte address per word and holds each write under a
//  valid/ready handshake. Signals completion once the last word of a tile is accepted.
//  Sits between the activation datapath and the output-buffer write port.
// PARAMETERS
//  DATA_W  16  activation width (`HWORD)
//  WORD_W  32  packed output word width (must equal 2*DATA_W)
//  ADDR_W  16  byte-address and element-count width
// PORTS
//  clk        in   1       clock, rising edge
//  rstn       in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse; latches base_addr and num_elems when idle
//  base_addr  in   ADDR_W  byte address of the first output word (4-byte aligned)
//  num_elems  in   ADDR_W  number of halfwords in this tile
//  in_valid   in   1       activation sample valid
//  in_ready   out  1       packer accepts a sample this cycle
//  in_data    in   DATA_W  activation sample (two's complement, passed through unchanged)
//  out_valid  out  1       write request valid
//  out_ready  in   1       buffer accepts the write this cycle
//  out_addr   out  ADDR_W  byte address of the write
//  out_data   out  WORD_W  packed word: {second sample, first sample}
//  out_wstrb  out  4       byte enables
//  busy       out  1       tile in progress (any state except IDLE)
//  done       out  1       1-cycle pulse at tile completion
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; in_ready, out_valid, busy and done = 0.
//   out_addr, out_data and out_wstrb = 0; element and word counters = 0.
//  FSM states IDLE, LO, HI, EMIT, DONE.
//   IDLE: on start with num_elems!=0 -> LO (latch base, count). With num_elems==0 -> DONE.
//   LO:   in_ready=1; on in_valid: out_data[15:0]=in_data, remaining-1.
//         If remaining is now 0 -> EMIT with wstrb=4'b0011 and out_data[31:16]=0.
//         Otherwise -> HI.
//   HI:   in_ready=1; on in_valid: out_data[31:16]=in_data, wstrb=4'b1111, remaining-1 -> EMIT.
//   EMIT: out_valid=1; out_data, out_addr and out_wstrb are held stable until out_ready.
//         On out_ready: out_addr+=4. Then -> LO if remaining!=0, else -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  in_ready is 0 in IDLE, EMIT and DONE. No sample is accepted while a word is pending.
//  Latency: a word is presented in the cycle after its last sample is accepted.
//  Peak throughput: 2 samples per 3 cycles.
//  out_addr for the first word = base_addr. It wraps modulo 2^ADDR_W (0xFFFC+4 -> 0x0000).
//  start while busy=1 is ignored. The latched base and count do not change.
//  Odd num_elems: the final word is a half word (wstrb 0011) with the upper 16 bits zero.
//  Reset mid-tile: the partial word is discarded and no write is emitted.
//  No data arithmetic is performed. Samples are bit-exact copies of in_data.
// TESTING
//  1 num_elems=4, base=0x0100, in 0x0001,0x0002,0x0003,0x0004, out_ready=1
//    -> writes (0x0100,0x00020001,F) and (0x0104,0x00040003,F); one done pulse.
//  2 num_elems=3, base=0x0200, in 0xFFF0,0x0010,0x8001
//    -> writes (0x0200,0x0010FFF0,F) and (0x0204,0x00008001,3); then done.
//  3 num_elems=0, start -> done the next cycle; out_valid never asserts; busy high for 1 cycle.
//  4 Backpressure: out_ready=0 for 5 cycles during EMIT.
//    -> out_valid, out_data and out_addr are stable; in_ready=0 throughout.
//    -> exactly one write occurs when out_ready rises.
//  5 base=0xFFFC, num_elems=4 -> write addresses 0xFFFC then 0x0000.
//  6 Issue start during a busy tile; separately, drop rstn after 1 sample.
//    -> the extra start is ignored; after reset there is no write, all outputs are 0, state is IDLE.

Source files
------------

// File: rtl/dla_act_packer_if.sv
// Activation-in / packed-write-out bus of the DLA activation packer.
// The master modport is the packer; the slave modport is its environment.
interface dla_act_packer_if #(
    parameter int DATA_W = 16,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [WORD_W-1:0] out_data;
    logic [3:0]        out_wstrb;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_data, out_wstrb
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_data, out_wstrb
    );
endinterface

// File: rtl/dla_act_packer.sv
// Packs pairs of 16-bit activations into 32-bit output-buffer writes with an
// incrementing byte address; pulses done after the last word of a tile is accepted.
module dla_act_packer #(
    parameter int DATA_W = 16,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_elems,
    dla_act_packer_if.master  bus,
    output logic              busy,
    output logic              done
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LO   = 3'd1;
    localparam logic [2:0] HI   = 3'd2;
    localparam logic [2:0] EMIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] remaining;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            remaining     <= '0;
            bus.out_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_elems != '0) begin
                            state        <= LO;
                            remaining    <= num_elems;
                            bus.out_addr <= base_addr;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LO: begin
                    if (bus.in_valid) begin
                        // Upper half cleared so an odd tail word carries zeros.
                        bus.out_data <= {{(WORD_W-DATA_W){1'b0}}, bus.in_data};
                        remaining    <= remaining - ADDR_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            state         <= EMIT;
                            bus.out_wstrb <= 4'b0011;
                        end else begin
                            state <= HI;
                        end
                    end
                end
                HI: begin
                    if (bus.in_valid) begin
                        bus.out_data  <= {bus.in_data, bus.out_data[DATA_W-1:0]};
                        bus.out_wstrb <= 4'b1111;
                        remaining     <= remaining - ADDR_W'(1);
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_addr <= bus.out_addr + ADDR_W'(4);
                        state        <= (remaining != '0) ? LO : DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == LO) || (state == HI);
        bus.out_valid = (state == EMIT);
        busy          = (state != IDLE);
        done          = (state == DONE);
    end
endmodule

// File: tb/tb_dla_act_packer.sv
// Directed bench for dla_act_packer: a tile-level model predicts every write,
// and a negedge monitor checks writes, hold-under-backpressure and in_ready.
module tb_dla_act_packer;
    localparam int DATA_W = 16;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] num_elems = '0;
    logic              busy;
    logic              done;

    dla_act_packer_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    dla_act_packer #(.DATA_W(DATA_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .num_elems (num_elems),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] smp[$];
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int valid_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Tile model: word k holds samples 2k and 2k+1 at base + 4k; an odd tail is a half word.
    function automatic void model_tile(input logic [15:0] base);
        int n;
        wr_t w;
        n = smp.size();
        for (int k = 0; k < n; k += 2) begin
            w.addr = base + 16'(2 * k);
            w.data = {(k + 1 < n) ? smp[k+1] : 16'h0000, smp[k]};
            w.strb = (k + 1 < n) ? 4'hF : 4'h3;
            exp_q.push_back(w);
        end
    endfunction

    logic pend = 1'b0;
    wr_t  held;
    wr_t  e;

    always @(negedge clk) begin
        if (!rstn) begin
            pend = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (pend) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_addr", 32'(bus.out_addr), 32'(held.addr));
                chk("hold_data", bus.out_data, held.data);
                chk("hold_wstrb", 32'(bus.out_wstrb), 32'(held.strb));
            end
            if (bus.out_valid) begin
                valid_cycles++;
                chk("in_ready_while_emit", 32'(bus.in_ready), 32'd0);
                if (bus.out_ready) begin
                    pend = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual addr=0x%04h data=0x%08h required=no write",
                                 bus.out_addr, bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 32'(bus.out_addr), 32'(e.addr));
                        chk("write_data", bus.out_data, e.data);
                        chk("write_wstrb", 32'(bus.out_wstrb), 32'(e.strb));
                    end
                end else begin
                    pend = 1'b1;
                    held = {bus.out_addr, bus.out_data, bus.out_wstrb};
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic start_tile(input logic [15:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_elems = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 16'hDEAD; num_elems = 16'h0007;
    endtask

    task automatic feed(input int first, input int last);
        bit ok;
        for (int i = first; i < last; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = smp[i];
            ok = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                chk("feed_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int t = 0; t < 200 && done_cnt == d0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int v0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_wstrb", 32'(bus.out_wstrb), 32'd0);
        rstn = 1'b1;

        // Four samples, free-flowing output
        smp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        model_tile(16'h0100);
        chk("model1_w0", exp_q[0].data, 32'h00020001);
        chk("model1_a1", 32'(exp_q[1].addr), 32'h0104);
        chk("model1_w1", exp_q[1].data, 32'h00040003);
        d0 = done_cnt;
        start_tile(16'h0100, 16'd4);
        feed(0, 4);
        wait_done(d0, "t1");

        // Odd count: half-word tail
        smp = '{16'hFFF0, 16'h0010, 16'h8001};
        model_tile(16'h0200);
        chk("model2_w0", exp_q[0].data, 32'h0010FFF0);
        chk("model2_w1", exp_q[1].data, 32'h00008001);
        chk("model2_s1", 32'(exp_q[1].strb), 32'h3);
        d0 = done_cnt;
        start_tile(16'h0200, 16'd3);
        feed(0, 3);
        wait_done(d0, "t2");

        // Empty tile
        v0 = valid_cycles;
        d0 = done_cnt;
        start_tile(16'h0500, 16'd0);
        chk("t3_done_high", 32'(done), 32'd1);
        chk("t3_busy_high", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t3_done_low", 32'(done), 32'd0);
        chk("t3_busy_low", 32'(busy), 32'd0);
        wait_done(d0, "t3");
        chk("t3_no_write", 32'(valid_cycles - v0), 32'd0);

        // Backpressure held for five cycles
        bus.out_ready = 1'b0;
        smp = '{16'hAAAA, 16'h5555};
        model_tile(16'h0600);
        d0 = done_cnt;
        start_tile(16'h0600, 16'd2);
        feed(0, 2);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_valid_held", 32'(bus.out_valid), 32'd1);
        chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t4_no_write_yet", 32'(exp_q.size()), 32'd1);
        bus.out_ready = 1'b1;
        wait_done(d0, "t4");

        // Address wrap
        smp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        model_tile(16'hFFFC);
        chk("model5_a0", 32'(exp_q[0].addr), 32'hFFFC);
        chk("model5_a1", 32'(exp_q[1].addr), 32'h0000);
        d0 = done_cnt;
        start_tile(16'hFFFC, 16'd4);
        feed(0, 4);
        wait_done(d0, "t5");

        // Start while busy is ignored
        smp = '{16'h0A0A, 16'h0B0B};
        model_tile(16'h0300);
        d0 = done_cnt;
        start_tile(16'h0300, 16'd2);
        feed(0, 1);
        start_tile(16'h0900, 16'd6);
        feed(1, 2);
        wait_done(d0, "t6a");

        // Reset after one sample discards the partial word
        smp = '{16'h7777, 16'h8888, 16'h9999, 16'hAAAA};
        start_tile(16'h0400, 16'd4);
        feed(0, 1);
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6b_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t6b_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_done", 32'(done), 32'd0);
        chk("t6b_out_addr", 32'(bus.out_addr), 32'd0);
        chk("t6b_out_data", bus.out_data, 32'd0);
        chk("t6b_out_wstrb", 32'(bus.out_wstrb), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        v0 = valid_cycles;
        repeat (10) @(posedge clk);
        #1;
        chk("t6b_no_write", 32'(valid_cycles - v0), 32'd0);
        chk("t6b_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
